riscv_div_unit: RTL and testbench
=================================

Name: riscv_div_unit

Overview:
- Parametrised iterative integer divider for the RV32M/RV64M execute stage; implements DIV, DIVU, REM and REMU.
- Uses a restoring shift-subtract datapath that retires STEPS quotient bits per cycle.
- Adds a start/valid handshake, an abort (kill) input, and single-cycle fast paths for divide-by-zero and signed overflow.
- Drives the pipeline stall line while a division is in flight.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- STEPS, 1, quotient bits resolved per cycle; legal values 1, 2, 4; must divide XLEN (elaboration error otherwise).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU; latched on start.
- a  in  XLEN  dividend; latched on start.
- b  in  XLEN  divisor; latched on start.
- kill  in  1  synchronous abort (pipeline flush).
- busy  out  1  high in any state other than IDLE.
- valid  out  1  one-cycle pulse; result is valid in that cycle.
- result  out  XLEN  quotient or remainder, selected by the latched op.
- div_zero  out  1  qualifies valid: divisor was zero.
- overflow  out  1  qualifies valid: signed overflow (DIV/REM of most-negative by -1).
- stall  out  1  freezes the pipeline while a division is in flight.

Behaviour:
- Reset: state=IDLE; busy, valid, result, div_zero, overflow, stall all 0; counter=0. Reset asserted mid-operation abandons the operation with no valid.
- States: IDLE, ABS, CALC, FIX, DONE.
- IDLE:
  - With start=1 and kill=0: latch a, b, op; compute zero = (b==0) and ovf = signed op && a==MIN && b==all-ones.
  - If zero or ovf: go to DONE. Otherwise go to ABS.
- ABS:
  - Signed ops: replace each negative operand with its two's complement magnitude. Unsigned ops: pass operands through.
  - Clear the remainder register, load counter = XLEN/STEPS, go to CALC.
- CALC:
  - Each cycle performs STEPS chained restoring steps. Per step: trial = {rem, q_msb} - d, computed XLEN+1 bits wide. If trial is non-negative, rem = trial and shift in 1; otherwise shift rem left with q_msb and shift in 0.
  - Counter decrements every cycle; at counter==1 go to FIX.
- FIX (signed ops only):
  - Quotient is negated when sign(a) != sign(b).
  - Remainder is negated when a is negative.
  - Unsigned ops pass through. Go to DONE.
- DONE:
  - valid=1 for exactly one cycle, then return to IDLE.
  - result = quotient for DIV/DIVU, remainder for REM/REMU.
  - Divide-by-zero: quotient = all-ones, remainder = a (both signed and unsigned).
  - Overflow: quotient = MIN, remainder = 0.
  - div_zero/overflow are meaningful only while valid=1; otherwise 0.
- result holds its value after DONE until the next accepted start.
- Latency, counting the start edge as cycle 0:
  - Normal path: valid in cycle XLEN/STEPS+3 (35 for XLEN=32, STEPS=1; 19 for STEPS=2).
  - Fast path: valid in cycle 1.
- stall = (state==IDLE && start && !kill) || state in {ABS, CALC, FIX}. stall is low in DONE so the pipeline consumes result in that cycle.
- kill:
  - In ABS, CALC, FIX or DONE: next state IDLE; no valid (valid forced 0 in that cycle if in DONE); result unchanged.
  - kill has priority over start in the same cycle.
- start while busy is ignored; no queuing. start is accepted again in the cycle after DONE; back-to-back operations are separated by one IDLE cycle.
- Counter width: clog2(XLEN/STEPS)+1. Counter never wraps; it is reloaded only in ABS.

Test Plan:
- XLEN=32, STEPS=1: DIV a=-7 b=2 -> result 0xFFFFFFFD, valid in cycle 35. REM same operands -> 0xFFFFFFFF. stall high cycles 0-34, low in 35.
- DIVU a=0xFFFFFFFF b=3 -> 0x55555555. REMU a=0xFFFFFFFF b=0x10 -> 0x0000000F. REM a=7 b=-2 -> 1.
- DIV a=5 b=0 -> 0xFFFFFFFF with div_zero=1, valid in cycle 1. REMU a=5 b=0 -> 5.
- DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000 with overflow=1, valid in cycle 1. REM same operands -> 0.
- Abort/reset: kill in cycle 10 of a DIV -> busy low in cycle 11, no valid. A new DIVU 100/7 started in cycle 11 -> 14. rst pulse mid-CALC -> all outputs 0 immediately.
- STEPS=2 and XLEN=64: random signed/unsigned sweep vs reference model. Latency 19 (XLEN=32) / 35 (XLEN=64). start asserted while busy is ignored.

Source files
------------

// File: rtl/riscv_div_unit_if.sv
// Request/response bundle between the execute stage and the iterative divider.
// Handshake: start is taken only while busy is low and kill is low; valid is a one-cycle result strobe.
interface riscv_div_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            kill;
    logic            busy;
    logic            valid;
    logic [XLEN-1:0] result;
    logic            div_zero;
    logic            overflow;
    logic            stall;
    logic [2:0]      state_dbg;

    modport master (
        output start, op, a, b, kill,
        input  busy, valid, result, div_zero, overflow, stall, state_dbg
    );

    modport slave (
        input  start, op, a, b, kill,
        output busy, valid, result, div_zero, overflow, stall, state_dbg
    );
endinterface

// File: rtl/riscv_div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, STEPS quotient bits per cycle,
// with one-cycle fast paths for divide-by-zero and signed overflow.
module riscv_div_unit #(
    parameter int XLEN  = 32,
    parameter int STEPS = 1
) (
    input  logic              clk,
    input  logic              rst,
    riscv_div_unit_if.slave   io
);
    localparam int ITERS = XLEN / STEPS;
    localparam int CNT_W = $clog2(ITERS) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    generate
        if (!((XLEN == 32) || (XLEN == 64)) || !((STEPS == 1) || (STEPS == 2) || (STEPS == 4))
            || (XLEN % STEPS != 0)) begin : g_bad_params
            $error("riscv_div_unit: unsupported XLEN/STEPS combination");
        end
    endgenerate

    typedef enum logic [2:0] {S_IDLE, S_ABS, S_CALC, S_FIX, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   q_q, rem_q, d_q, result_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        op_q;
    logic              a_neg_q, b_neg_q, zero_q, ovf_q;

    logic              signed_in, accept, zero_in, ovf_in;
    logic [XLEN-1:0]   q_step, rem_step, r_w, qq_w;
    logic [XLEN:0]     num_w;
    logic              ge_w;
    logic [XLEN-1:0]   quot_fin, rem_fin, res_fin;

    assign signed_in = ~io.op[0];
    assign accept    = (state_q == S_IDLE) && io.start && !io.kill;
    assign zero_in   = (io.b == '0);
    assign ovf_in    = signed_in && (io.a == MIN_NEG) && (io.b == '1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = (zero_in || ovf_in) ? S_DONE : S_ABS;
            S_ABS:  state_d = S_CALC;
            S_CALC: if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (io.kill && state_q != S_IDLE) state_d = S_IDLE;
    end

    // STEPS chained restoring steps; the partial difference is always below d, so XLEN bits hold it.
    always_comb begin
        r_w   = rem_q;
        qq_w  = q_q;
        num_w = '0;
        ge_w  = 1'b0;
        for (int i = 0; i < STEPS; i++) begin
            num_w = {r_w, qq_w[XLEN-1]};
            ge_w  = (num_w >= {1'b0, d_q});
            r_w   = ge_w ? (num_w[XLEN-1:0] - d_q) : num_w[XLEN-1:0];
            qq_w  = {qq_w[XLEN-2:0], ge_w};
        end
        rem_step = r_w;
        q_step   = qq_w;
    end

    // On the fast paths q_q still holds the raw dividend.
    assign quot_fin = zero_q ? '1   : (ovf_q ? MIN_NEG : q_q);
    assign rem_fin  = zero_q ? q_q  : (ovf_q ? '0      : rem_q);
    assign res_fin  = op_q[1] ? rem_fin : quot_fin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q      <= '0;
            rem_q    <= '0;
            d_q      <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    q_q     <= io.a;
                    d_q     <= io.b;
                    op_q    <= io.op;
                    a_neg_q <= signed_in & io.a[XLEN-1];
                    b_neg_q <= signed_in & io.b[XLEN-1];
                    zero_q  <= zero_in;
                    ovf_q   <= ovf_in;
                end
                S_ABS: begin
                    if (a_neg_q) q_q <= -q_q;
                    if (b_neg_q) d_q <= -d_q;
                    rem_q <= '0;
                    cnt_q <= CNT_W'(ITERS);
                end
                S_CALC: begin
                    q_q   <= q_step;
                    rem_q <= rem_step;
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                S_FIX: begin
                    if (a_neg_q ^ b_neg_q) q_q <= -q_q;
                    if (a_neg_q)           rem_q <= -rem_q;
                end
                S_DONE: if (!io.kill) result_q <= res_fin;
                default: ;
            endcase
        end
    end

    assign io.busy      = (state_q != S_IDLE);
    assign io.valid     = (state_q == S_DONE) && !io.kill;
    assign io.div_zero  = io.valid && zero_q;
    assign io.overflow  = io.valid && ovf_q;
    assign io.result    = io.valid ? res_fin : result_q;
    assign io.stall     = accept || (state_q == S_ABS) || (state_q == S_CALC) || (state_q == S_FIX);
    assign io.state_dbg = state_q;
endmodule

// File: tb/tb_riscv_div_unit.sv
// Bench for riscv_div_unit: three configurations (32/1, 32/2, 64/2) driven in lockstep
// and compared against an arithmetic reference model.
module tb_riscv_div_unit;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    riscv_div_unit_if #(.XLEN(32)) if0();
    riscv_div_unit_if #(.XLEN(32)) if1();
    riscv_div_unit_if #(.XLEN(64)) if2();

    riscv_div_unit #(.XLEN(32), .STEPS(1)) u_dut0 (.clk(clk), .rst(rst), .io(if0));
    riscv_div_unit #(.XLEN(32), .STEPS(2)) u_dut1 (.clk(clk), .rst(rst), .io(if1));
    riscv_div_unit #(.XLEN(64), .STEPS(2)) u_dut2 (.clk(clk), .rst(rst), .io(if2));

    int XL[3]  = '{32, 32, 64};
    int LAT[3] = '{35, 19, 35};

    logic [63:0] cap_res[3];
    logic        cap_dz[3];
    logic        cap_ov[3];
    int          cap_cyc[3];
    int          cap_nv[3];
    logic [47:0] cap_stall;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer division with the RISC-V special cases.
    function automatic logic [65:0] model(input logic [1:0] op, input logic [63:0] a_in,
                                          input logic [63:0] b_in, input int xlen);
        logic [63:0] mask, mn, a, b, res;
        logic        dz, ov;
        longint      sa, sb;
        mask = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        mn   = (xlen == 32) ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
        a = a_in & mask;
        b = b_in & mask;
        dz = 1'b0;
        ov = 1'b0;
        if (b == 64'd0) begin
            dz  = 1'b1;
            res = op[1] ? a : mask;
        end else if (!op[0] && a == mn && b == mask) begin
            ov  = 1'b1;
            res = op[1] ? 64'd0 : mn;
        end else if (!op[0]) begin
            if (xlen == 32) begin
                sa = longint'($signed(a[31:0]));
                sb = longint'($signed(b[31:0]));
            end else begin
                sa = $signed(a);
                sb = $signed(b);
            end
            res = (op[1] ? 64'(sa % sb) : 64'(sa / sb)) & mask;
        end else begin
            res = op[1] ? (a % b) : (a / b);
        end
        return {dz, ov, res};
    endfunction

    task automatic set_in(input logic st, input logic [1:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic kl);
        if0.start = st; if0.op = op; if0.a = a[31:0]; if0.b = b[31:0]; if0.kill = kl;
        if1.start = st; if1.op = op; if1.a = a[31:0]; if1.b = b[31:0]; if1.kill = kl;
        if2.start = st; if2.op = op; if2.a = a;       if2.b = b;       if2.kill = kl;
    endtask

    task automatic sample(input int c);
        if (c < 48) cap_stall[c] = if0.stall;
        if (if0.valid) begin
            if (cap_nv[0] == 0) begin
                cap_cyc[0] = c; cap_res[0] = {32'd0, if0.result};
                cap_dz[0] = if0.div_zero; cap_ov[0] = if0.overflow;
            end
            cap_nv[0]++;
        end
        if (if1.valid) begin
            if (cap_nv[1] == 0) begin
                cap_cyc[1] = c; cap_res[1] = {32'd0, if1.result};
                cap_dz[1] = if1.div_zero; cap_ov[1] = if1.overflow;
            end
            cap_nv[1]++;
        end
        if (if2.valid) begin
            if (cap_nv[2] == 0) begin
                cap_cyc[2] = c; cap_res[2] = if2.result;
                cap_dz[2] = if2.div_zero; cap_ov[2] = if2.overflow;
            end
            cap_nv[2]++;
        end
    endtask

    // Start one operation in cycle 0 and watch a bounded window; extra_c > 0 re-asserts
    // start with different operands in that cycle.
    task automatic run_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                          input int extra_c);
        for (int k = 0; k < 3; k++) begin
            cap_res[k] = '0; cap_dz[k] = 1'b0; cap_ov[k] = 1'b0; cap_cyc[k] = -1; cap_nv[k] = 0;
        end
        cap_stall = '0;
        @(negedge clk);
        set_in(1'b1, op, a, b, 1'b0);
        #1 sample(0);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == extra_c) set_in(1'b1, ~op, ~a, b + 64'd3, 1'b0);
            else              set_in(1'b0, op, a, b, 1'b0);
            #1 sample(c);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        set_in(1'b0, 2'b00, 64'd0, 64'd0, 1'b0);
        repeat (3) @(negedge clk);
        n_checks++;
        if ({if0.busy, if0.valid, if0.div_zero, if0.overflow, if0.stall, if0.result} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_outputs dut0 busy=%b valid=%b result=%h stall=%b required all zero",
                     if0.busy, if0.valid, if0.result, if0.stall);
        end
        n_checks++;
        if ({if2.busy, if2.valid, if2.div_zero, if2.overflow, if2.stall, if2.result} !== 69'd0) begin
            n_fail++;
            $display("FAIL reset_outputs dut2 busy=%b valid=%b result=%h required all zero",
                     if2.busy, if2.valid, if2.result);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [1:0]  t_op[9]  = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b10, 2'b00, 2'b11, 2'b00, 2'b10};
        logic [31:0] t_a[9]   = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7,
                                  32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] t_b[9]   = '{32'd2, 32'd2, 32'd3, 32'h10, 32'hFFFF_FFFE,
                                  32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] t_exp[9] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h5555_5555, 32'h0000_000F, 32'd1,
                                  32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        logic        t_dz[9]  = '{0, 0, 0, 0, 0, 1, 1, 0, 0};
        logic        t_ov[9]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
        logic [63:0] a64, b64;
        logic [65:0] m;
        logic [47:0] es;
        int          lat0, exp_lat;
        for (int i = 0; i < 9; i++) begin
            a64 = {{32{t_a[i][31]}}, t_a[i]};
            b64 = {{32{t_b[i][31]}}, t_b[i]};
            run_op(t_op[i], a64, b64, 0);
            lat0 = (t_dz[i] | t_ov[i]) ? 1 : 35;
            n_checks++;
            if (cap_res[0][31:0] !== t_exp[i] || cap_dz[0] !== t_dz[i] || cap_ov[0] !== t_ov[i]) begin
                n_fail++;
                $display("FAIL directed_result #%0d got=%h dz=%b ov=%b required=%h dz=%b ov=%b",
                         i, cap_res[0][31:0], cap_dz[0], cap_ov[0], t_exp[i], t_dz[i], t_ov[i]);
            end
            n_checks++;
            if (cap_cyc[0] != lat0 || cap_nv[0] != 1) begin
                n_fail++;
                $display("FAIL directed_latency #%0d cycle=%0d pulses=%0d required cycle=%0d pulses=1",
                         i, cap_cyc[0], cap_nv[0], lat0);
            end
            es = '0;
            for (int c = 0; c < lat0; c++) es[c] = 1'b1;
            n_checks++;
            if (cap_stall !== es) begin
                n_fail++;
                $display("FAIL directed_stall #%0d got=%h required=%h", i, cap_stall, es);
            end
            for (int k = 1; k < 3; k++) begin
                m = model(t_op[i], a64, b64, XL[k]);
                exp_lat = (m[65] | m[64]) ? 1 : LAT[k];
                n_checks++;
                if ({cap_dz[k], cap_ov[k], cap_res[k]} !== m || cap_cyc[k] != exp_lat || cap_nv[k] != 1) begin
                    n_fail++;
                    $display("FAIL directed_model #%0d dut%0d got=%h cycle=%0d required=%h cycle=%0d",
                             i, k, {cap_dz[k], cap_ov[k], cap_res[k]}, cap_cyc[k], m, exp_lat);
                end
            end
        end
    endtask

    task automatic test_random;
        logic [1:0]  op;
        logic [63:0] a, b;
        logic [65:0] m;
        int          exp_lat;
        for (int n = 0; n < 30; n++) begin
            op = 2'($urandom_range(0, 3));
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: ;
                1: b = ($urandom_range(0, 1) == 1) ? 64'($urandom_range(1, 20)) : -64'($urandom_range(1, 20));
                2: b = 64'd0;
                3: begin a = 64'hFFFF_FFFF_8000_0000; b = '1; end
                4: begin a = 64'h8000_0000_0000_0000; b = '1; end
                default: begin a = -64'($urandom_range(0, 5000)); b = 64'($urandom_range(1, 97)); end
            endcase
            run_op(op, a, b, 0);
            for (int k = 0; k < 3; k++) begin
                m = model(op, a, b, XL[k]);
                exp_lat = (m[65] | m[64]) ? 1 : LAT[k];
                n_checks++;
                if ({cap_dz[k], cap_ov[k], cap_res[k]} !== m) begin
                    n_fail++;
                    $display("FAIL random_result dut%0d op=%0d a=%h b=%h got=%h required=%h",
                             k, op, a, b, {cap_dz[k], cap_ov[k], cap_res[k]}, m);
                end
                n_checks++;
                if (cap_cyc[k] != exp_lat || cap_nv[k] != 1) begin
                    n_fail++;
                    $display("FAIL random_latency dut%0d op=%0d cycle=%0d pulses=%0d required cycle=%0d pulses=1",
                             k, op, cap_cyc[k], cap_nv[k], exp_lat);
                end
            end
        end
    endtask

    task automatic test_busy_ignore;
        logic [63:0] a, b;
        logic [65:0] m;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom | 32'd1};
        run_op(2'b01, a, b, 5);
        for (int k = 0; k < 3; k++) begin
            m = model(2'b01, a, b, XL[k]);
            n_checks++;
            if ({cap_dz[k], cap_ov[k], cap_res[k]} !== m || cap_cyc[k] != LAT[k] || cap_nv[k] != 1) begin
                n_fail++;
                $display("FAIL busy_ignore dut%0d got=%h cycle=%0d pulses=%0d required=%h cycle=%0d pulses=1",
                         k, cap_res[k], cap_cyc[k], cap_nv[k], m[63:0], LAT[k]);
            end
        end
    endtask

    task automatic test_kill;
        logic [31:0] prev;
        int          nv;
        prev = cap_res[0][31:0];
        nv   = 0;
        @(negedge clk);
        set_in(1'b1, 2'b00, -64'd100, 64'd3, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            set_in(1'b0, 2'b00, -64'd100, 64'd3, c == 10);
            #1 if (if0.valid) nv++;
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (if0.busy !== 1'b0 || nv != 0 || if0.result !== prev) begin
            n_fail++;
            $display("FAIL kill_calc busy=%b pulses=%0d result=%h required busy=0 pulses=0 result=%h",
                     if0.busy, nv, if0.result, prev);
        end
        run_op(2'b01, 64'd100, 64'd7, 0);
        n_checks++;
        if (cap_res[0] !== 64'd14 || cap_cyc[0] != 35 || cap_nv[0] != 1) begin
            n_fail++;
            $display("FAIL kill_restart got=%h cycle=%0d required=0000000e cycle=35", cap_res[0], cap_cyc[0]);
        end
        nv = 0;
        @(negedge clk);
        set_in(1'b1, 2'b00, 64'd1000, 64'd7, 1'b0);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            set_in(1'b0, 2'b00, 64'd1000, 64'd7, c == 35);
            #1 if (if0.valid) nv++;
        end
        n_checks++;
        if (nv != 0 || if0.busy !== 1'b0 || if0.result !== 32'd14) begin
            n_fail++;
            $display("FAIL kill_done pulses=%0d busy=%b result=%h required pulses=0 busy=0 result=0000000e",
                     nv, if0.busy, if0.result);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_q[$];
        int          exp_c[$];
        logic [31:0] e;
        int          ec;
        exp_q = {32'hFFFF_FFFF, 32'd9};
        exp_c = {1, 3};
        @(negedge clk);
        set_in(1'b1, 2'b00, 64'd5, 64'd0, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            set_in(c == 1 || c == 2, 2'b11, 64'd9, 64'd0, 1'b0);
            #1;
            if (if0.valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL back_to_back_extra cycle=%0d result=%h required no pulse", c, if0.result);
                end else begin
                    e  = exp_q.pop_front();
                    ec = exp_c.pop_front();
                    if (if0.result !== e || c != ec || if0.div_zero !== 1'b1) begin
                        n_fail++;
                        $display("FAIL back_to_back_result cycle=%0d result=%h dz=%b required cycle=%0d result=%h dz=1",
                                 c, if0.result, if0.div_zero, ec, e);
                    end
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL back_to_back_missing outstanding=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid;
        int nv;
        nv = 0;
        @(negedge clk);
        set_in(1'b1, 2'b00, 64'd12345, 64'd11, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            set_in(1'b0, 2'b00, 64'd12345, 64'd11, 1'b0);
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({if0.busy, if0.valid, if0.div_zero, if0.overflow, if0.stall, if0.result} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_mid busy=%b valid=%b stall=%b result=%h required all zero",
                     if0.busy, if0.valid, if0.stall, if0.result);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1 if (if0.valid || if0.busy) nv++;
        end
        n_checks++;
        if (nv != 0) begin
            n_fail++;
            $display("FAIL reset_mid_abandon active_cycles=%0d required 0", nv);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_kill();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
